preadder_checker: RTL and testbench

PREADDER_CHECKER -- requirements
Module: preadder_checker

---
 rtl/preadder_checker.sv | 187 ++++++++++++++++++
 tb/tb_preadder_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/preadder_checker.sv
// Pre-adder result checker: models AMULT from A/D/INMODE and compares LATENCY cycles later.
// Latency: compare LATENCY cycles after the sample; counters/flags update on the edge after the compare.
// Backpressure: none, passive monitor. Optional capture of the first mismatch via PREADDER_CHECKER_CAPTURE_EN.
module preadder_checker #(
    parameter int LATENCY     = 2,
    parameter bit USE_DPORT   = 1'b1,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        EN,
    input  logic        CLR,
    input  logic        VALID_IN,
    input  logic [29:0] A,
    input  logic [24:0] D,
    input  logic [3:0]  INMODE,
    input  logic [24:0] AMULT,
    output logic        BUSY,
    output logic        ERR,
    output logic [15:0] PASS_CNT,
    output logic [15:0] ERR_CNT,
    output logic [24:0] FIRST_EXP,
    output logic [24:0] FIRST_ACT,
    output logic [3:0]  FIRST_INMODE
);

    typedef struct packed {
        logic [24:0] exp;
        logic [3:0]  inmode;
        logic        vld;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

    state_t      state, next_state;
    logic [24:0] a25;
    logic [24:0] exp_val;
    entry_t      push;
    entry_t      out_e;
    logic        remain;
    logic        flush;
    logic        cmp_hit;
    logic        cmp_miss;
    logic        err_q;
    logic [15:0] pass_q;
    logic [15:0] errc_q;

    assign a25 = A[24:0];

    // INMODE[3] negates A, INMODE[2] enables D, INMODE[1] zeroes A.
    always_comb begin
        exp_val = '0;
        if (USE_DPORT) begin
            case (INMODE[3:1])
                3'b000:         exp_val = a25;
                3'b010:         exp_val = D + a25;
                3'b011, 3'b111: exp_val = D;
                3'b100:         exp_val = '0 - a25;
                3'b110:         exp_val = D - a25;
                default:        exp_val = '0;
            endcase
        end else begin
            exp_val = INMODE[1] ? '0 : a25;
        end
    end

    always_comb begin
        push        = '0;
        push.exp    = exp_val;
        push.inmode = INMODE;
        push.vld    = (state == RUN) && VALID_IN;
    end

    generate
        if (LATENCY == 0) begin : g_nopipe
            assign out_e  = push;
            assign remain = 1'b0;
        end else begin : g_pipe
            entry_t pipe [LATENCY];

            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else if (flush) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i].vld <= 1'b0;
                end else begin
                    pipe[0] <= push;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign out_e = pipe[LATENCY-1];

            // Valid entries that survive past this cycle's compare.
            always_comb begin
                remain = 1'b0;
                for (int i = 0; i < LATENCY - 1; i++) remain = remain | pipe[i].vld;
            end
        end
    endgenerate

    assign cmp_hit  = out_e.vld && (AMULT == out_e.exp) && !CLR;
    assign cmp_miss = out_e.vld && (AMULT != out_e.exp) && !CLR;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (EN) next_state = RUN;
            RUN: begin
                if (cmp_miss && STOP_ON_ERR) next_state = HALT;
                else if (!EN)                next_state = DRAIN;
            end
            DRAIN: begin
                if (cmp_miss && STOP_ON_ERR) next_state = HALT;
                else if (EN)                 next_state = RUN;
                else if (!remain)            next_state = IDLE;
            end
            HALT:  if (CLR) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign flush = (next_state == HALT) && (state != HALT);
    assign BUSY  = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pass_q <= '0;
            errc_q <= '0;
            err_q  <= 1'b0;
        end else if (CLR) begin
            pass_q <= '0;
            errc_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cmp_hit && pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
            if (cmp_miss) begin
                err_q <= 1'b1;
                if (errc_q != 16'hFFFF) errc_q <= errc_q + 16'd1;
            end
        end
    end

    assign ERR      = err_q;
    assign PASS_CNT = pass_q;
    assign ERR_CNT  = errc_q;

`ifdef PREADDER_CHECKER_CAPTURE_EN
    logic [24:0] first_exp_q;
    logic [24:0] first_act_q;
    logic [3:0]  first_inmode_q;

    // err_q low means no mismatch yet since reset/CLR, so this is the first one.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            first_exp_q    <= '0;
            first_act_q    <= '0;
            first_inmode_q <= '0;
        end else if (CLR) begin
            first_exp_q    <= '0;
            first_act_q    <= '0;
            first_inmode_q <= '0;
        end else if (cmp_miss && !err_q) begin
            first_exp_q    <= out_e.exp;
            first_act_q    <= AMULT;
            first_inmode_q <= out_e.inmode;
        end
    end

    assign FIRST_EXP    = first_exp_q;
    assign FIRST_ACT    = first_act_q;
    assign FIRST_INMODE = first_inmode_q;
`else
    assign FIRST_EXP    = '0;
    assign FIRST_ACT    = '0;
    assign FIRST_INMODE = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{A[29:25], D, out_e.inmode, flush, remain};

endmodule

// File: tb/tb_preadder_checker.sv
// Directed bench for preadder_checker: default, STOP_ON_ERR and no-D-port/zero-latency instances share stimulus.
module tb_preadder_checker;

    logic        clk = 1'b0;
    logic        RST, EN, CLR, VALID_IN;
    logic [29:0] A;
    logic [24:0] D;
    logic [3:0]  INMODE;
    logic [24:0] AMULT;

    logic        d_busy, d_err, s_busy, s_err, n_busy, n_err;
    logic [15:0] d_pass, d_errc, s_pass, s_errc, n_pass, n_errc;
    logic [24:0] d_fexp, d_fact, s_fexp, s_fact, n_fexp, n_fact;
    logic [3:0]  d_fin, s_fin, n_fin;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PREADDER_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    always #5 clk = ~clk;

    preadder_checker #(.LATENCY(2), .USE_DPORT(1'b1), .STOP_ON_ERR(1'b0)) u_dut (
        .clk(clk), .RST(RST), .EN(EN), .CLR(CLR), .VALID_IN(VALID_IN), .A(A), .D(D),
        .INMODE(INMODE), .AMULT(AMULT), .BUSY(d_busy), .ERR(d_err), .PASS_CNT(d_pass),
        .ERR_CNT(d_errc), .FIRST_EXP(d_fexp), .FIRST_ACT(d_fact), .FIRST_INMODE(d_fin));

    preadder_checker #(.LATENCY(2), .USE_DPORT(1'b1), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .RST(RST), .EN(EN), .CLR(CLR), .VALID_IN(VALID_IN), .A(A), .D(D),
        .INMODE(INMODE), .AMULT(AMULT), .BUSY(s_busy), .ERR(s_err), .PASS_CNT(s_pass),
        .ERR_CNT(s_errc), .FIRST_EXP(s_fexp), .FIRST_ACT(s_fact), .FIRST_INMODE(s_fin));

    preadder_checker #(.LATENCY(0), .USE_DPORT(1'b0), .STOP_ON_ERR(1'b0)) u_nod (
        .clk(clk), .RST(RST), .EN(EN), .CLR(CLR), .VALID_IN(VALID_IN), .A(A), .D(D),
        .INMODE(INMODE), .AMULT(AMULT), .BUSY(n_busy), .ERR(n_err), .PASS_CNT(n_pass),
        .ERR_CNT(n_errc), .FIRST_EXP(n_fexp), .FIRST_ACT(n_fact), .FIRST_INMODE(n_fin));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic vld, input logic [29:0] a, input logic [24:0] d,
                        input logic [3:0] im, input logic [24:0] am);
        VALID_IN = vld; A = a; D = d; INMODE = im; AMULT = am;
        tick();
    endtask

    task automatic do_reset();
        VALID_IN = 0; A = '0; D = '0; INMODE = '0; AMULT = '0;
        EN = 0; CLR = 0; RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic start_run();
        EN = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", d_busy); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", d_err); end
        n_cmp++; if (d_pass !== 16'd0) begin n_bad++; $display("FAIL reset_pass: got %0d want 0", d_pass); end
        n_cmp++; if (d_errc !== 16'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", d_errc); end
        n_cmp++; if (d_fexp !== 25'd0) begin n_bad++; $display("FAIL reset_first_exp: got %h want 0", d_fexp); end
        start_run();
        n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b want 1", d_busy); end
    endtask

    task automatic test_preadd();
        do_reset();
        start_run();
        step(1, 30'd5, 25'd3, 4'b0100, 25'd0);
        step(0, 30'd0, 25'd0, 4'b0000, 25'd0);
        step(0, 30'd0, 25'd0, 4'b0000, 25'd8);
        n_cmp++; if (d_pass !== 16'd1) begin n_bad++; $display("FAIL preadd_pass: got %0d want 1", d_pass); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("FAIL preadd_err: got %b want 0", d_err); end
    endtask

    task automatic test_negate();
        do_reset();
        start_run();
        step(1, 30'd1, 25'd0, 4'b1000, 25'd0);
        step(1, 30'd1, 25'd0, 4'b1000, 25'd0);
        step(0, 30'd0, 25'd0, 4'b0000, 25'h1FFFFFF);
        step(0, 30'd0, 25'd0, 4'b0000, 25'd1);
        n_cmp++; if (d_pass !== 16'd1) begin n_bad++; $display("FAIL neg_pass: got %0d want 1", d_pass); end
        n_cmp++; if (d_errc !== 16'd1) begin n_bad++; $display("FAIL neg_errcnt: got %0d want 1", d_errc); end
        n_cmp++; if (d_err !== 1'b1) begin n_bad++; $display("FAIL neg_err: got %b want 1", d_err); end
        n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL neg_busy: got %b want 1", d_busy); end
        n_cmp++; if (d_fexp !== (CAP ? 25'h1FFFFFF : 25'd0)) begin n_bad++; $display("FAIL neg_first_exp: got %h want %h", d_fexp, CAP ? 25'h1FFFFFF : 25'd0); end
        n_cmp++; if (d_fact !== (CAP ? 25'd1 : 25'd0)) begin n_bad++; $display("FAIL neg_first_act: got %h want %h", d_fact, CAP ? 25'd1 : 25'd0); end
        n_cmp++; if (d_fin !== (CAP ? 4'b1000 : 4'b0000)) begin n_bad++; $display("FAIL neg_first_inmode: got %b want %b", d_fin, CAP ? 4'b1000 : 4'b0000); end
    endtask

    task automatic test_clr_priority();
        do_reset();
        start_run();
        step(1, 30'd1, 25'd0, 4'b0000, 25'd0);
        step(1, 30'd2, 25'd0, 4'b0000, 25'd0);
        step(0, 30'd0, 25'd0, 4'b0000, 25'd0);
        n_cmp++; if (d_errc !== 16'd1) begin n_bad++; $display("FAIL clr_pre_errcnt: got %0d want 1", d_errc); end
        CLR = 1;
        step(0, 30'd0, 25'd0, 4'b0000, 25'd0);
        CLR = 0;
        n_cmp++; if (d_errc !== 16'd0) begin n_bad++; $display("FAIL clr_errcnt: got %0d want 0", d_errc); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %b want 0", d_err); end
        n_cmp++; if (d_fexp !== 25'd0) begin n_bad++; $display("FAIL clr_first_exp: got %h want 0", d_fexp); end
    endtask

    task automatic test_stop_on_err();
        do_reset();
        start_run();
        step(1, 30'd10, 25'd0, 4'b0000, 25'd0);
        step(1, 30'd11, 25'd0, 4'b0000, 25'd0);
        step(1, 30'd12, 25'd0, 4'b0000, 25'd10);
        step(1, 30'd13, 25'd0, 4'b0000, 25'd99);
        step(1, 30'd14, 25'd0, 4'b0000, 25'd12);
        step(0, 30'd0,  25'd0, 4'b0000, 25'd13);
        step(0, 30'd0,  25'd0, 4'b0000, 25'd14);
        n_cmp++; if (s_pass !== 16'd1) begin n_bad++; $display("FAIL halt_pass: got %0d want 1", s_pass); end
        n_cmp++; if (s_errc !== 16'd1) begin n_bad++; $display("FAIL halt_errcnt: got %0d want 1", s_errc); end
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL halt_busy: got %b want 0", s_busy); end
        n_cmp++; if (s_err !== 1'b1) begin n_bad++; $display("FAIL halt_err: got %b want 1", s_err); end
        CLR = 1;
        step(0, 30'd0, 25'd0, 4'b0000, 25'd0);
        CLR = 0;
        n_cmp++; if (s_pass !== 16'd0) begin n_bad++; $display("FAIL halt_clr_pass: got %0d want 0", s_pass); end
        n_cmp++; if (s_errc !== 16'd0) begin n_bad++; $display("FAIL halt_clr_errcnt: got %0d want 0", s_errc); end
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL halt_clr_busy: got %b want 0", s_busy); end
        tick();
        n_cmp++; if (s_busy !== 1'b1) begin n_bad++; $display("FAIL halt_idle_to_run: got busy %b want 1", s_busy); end
    endtask

    task automatic test_drain();
        do_reset();
        start_run();
        step(1, 30'd7, 25'd0, 4'b0000, 25'd0);
        EN = 0;
        step(1, 30'd9, 25'd0, 4'b0000, 25'd0);
        n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy1: got %b want 1", d_busy); end
        step(0, 30'd0, 25'd0, 4'b0000, 25'd7);
        n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy2: got %b want 1", d_busy); end
        step(0, 30'd0, 25'd0, 4'b0000, 25'd9);
        n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL drain_idle_busy: got %b want 0", d_busy); end
        n_cmp++; if (d_pass !== 16'd2) begin n_bad++; $display("FAIL drain_pass: got %0d want 2", d_pass); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("FAIL drain_err: got %b want 0", d_err); end
    endtask

    task automatic test_no_dport();
        do_reset();
        start_run();
        step(1, 30'd123, 25'd5, 4'b0010, 25'd0);
        step(1, 30'h3FFFFFFF, 25'd0, 4'b0000, 25'h1FFFFFF);
        step(1, 30'd6, 25'd3, 4'b0100, 25'd9);
        VALID_IN = 0;
        n_cmp++; if (n_pass !== 16'd2) begin n_bad++; $display("FAIL nod_pass: got %0d want 2", n_pass); end
        n_cmp++; if (n_errc !== 16'd1) begin n_bad++; $display("FAIL nod_errcnt: got %0d want 1", n_errc); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start_run();
        step(1, 30'd1, 25'd0, 4'b0000, 25'd0);
        step(1, 30'd2, 25'd0, 4'b0000, 25'd0);
        step(1, 30'd3, 25'd0, 4'b0000, 25'd5);
        step(1, 30'd4, 25'd0, 4'b0000, 25'd2);
        n_cmp++; if (d_errc !== 16'd1 || d_pass !== 16'd1) begin n_bad++; $display("FAIL rst_pre_counts: got pass %0d err %0d want 1 1", d_pass, d_errc); end
        RST = 1;
        #2;
        n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", d_busy); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("FAIL rst_async_err: got %b want 0", d_err); end
        n_cmp++; if (d_pass !== 16'd0 || d_errc !== 16'd0) begin n_bad++; $display("FAIL rst_async_counts: got pass %0d err %0d want 0 0", d_pass, d_errc); end
        n_cmp++; if (d_fexp !== 25'd0 || d_fact !== 25'd0 || d_fin !== 4'd0) begin n_bad++; $display("FAIL rst_async_first: got %h %h %b want 0", d_fexp, d_fact, d_fin); end
        tick();
        RST = 0;
        step(0, 30'd0, 25'd0, 4'b0000, 25'd3);
        step(1, 30'd20, 25'd0, 4'b0000, 25'd4);
        n_cmp++; if (d_pass !== 16'd0 || d_errc !== 16'd0) begin n_bad++; $display("FAIL rst_no_stale_compare: got pass %0d err %0d want 0 0", d_pass, d_errc); end
        step(0, 30'd0, 25'd0, 4'b0000, 25'd0);
        step(0, 30'd0, 25'd0, 4'b0000, 25'd20);
        n_cmp++; if (d_pass !== 16'd1 || d_errc !== 16'd0) begin n_bad++; $display("FAIL rst_new_sample: got pass %0d err %0d want 1 0", d_pass, d_errc); end
    endtask

    task automatic test_saturation();
        do_reset();
        start_run();
        for (int i = 0; i < 65534; i++) step(1, 30'd0, 25'd0, 4'b0010, 25'd0);
        n_cmp++; if (n_pass !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre: got %h want fffe", n_pass); end
        for (int i = 0; i < 3; i++) step(1, 30'd0, 25'd0, 4'b0010, 25'd0);
        n_cmp++; if (n_pass !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", n_pass); end
        n_cmp++; if (n_errc !== 16'd0) begin n_bad++; $display("FAIL sat_errcnt: got %0d want 0", n_errc); end
    endtask

    initial begin
        RST = 1; EN = 0; CLR = 0; VALID_IN = 0;
        A = '0; D = '0; INMODE = '0; AMULT = '0;
        test_reset();
        test_preadd();
        test_negate();
        test_clr_priority();
        test_stop_on_err();
        test_drain();
        test_no_dport();
        test_reset_midrun();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
